// File: rtl/conv_tile_scheduler.sv
// conv_tile_scheduler
// Walks a fast-convolution engine (5x5 input tile -> 3x3 output tile) across a
// full input feature map. Overlapping 5x5 tiles are fetched with stride 3 from
// the ifmap memory, the engine is fired, and its 3x3 result is streamed into
// the ofmap memory. Weights are driven to the engine outside this block.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   job_start         one-cycle request to process one full map
//   busy / done / err job status (done is a one-cycle pulse; err is sticky)
//   rd_en/rd_addr     ifmap read port; rd_data arrives one cycle after rd_en
//   eng_start         one-cycle engine start pulse
//   eng_inputMAP      5x5 tile buffer, element r*5+c at [k*NBITS +: NBITS]
//   eng_outputMAP     3x3 engine result, eng_data_valid marks it valid
//   wr_en/wr_addr/wr_data  ofmap write port
module conv_tile_scheduler #(
    parameter int NBITS   = 16,
    parameter int TILES_X = 3,
    parameter int TILES_Y = 3,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 job_start,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 rd_en,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic [NBITS-1:0]     rd_data,
    output logic                 eng_start,
    output logic [25*NBITS-1:0]  eng_inputMAP,
    input  logic [9*NBITS-1:0]   eng_outputMAP,
    input  logic                 eng_data_valid,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [NBITS-1:0]     wr_data
);

    localparam int IMG_W = 3 * TILES_X + 2;
    localparam int OUT_W = 3 * TILES_X;
    localparam int TXW   = (TILES_X > 1) ? $clog2(TILES_X) : 1;
    localparam int TYW   = (TILES_Y > 1) ? $clog2(TILES_Y) : 1;
    localparam int TOW   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FIRE  = 3'd2,
        S_WAIT  = 3'd3,
        S_DRAIN = 3'd4,
        S_NEXT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [TXW-1:0]        tx_q, tx_d;
    logic [TYW-1:0]        ty_q, ty_d;
    logic [4:0]            ld_cnt_q, ld_cnt_d;   // LOAD cycle index 0..25
    logic [2:0]            rr_q, rr_d;           // row of the read on the bus
    logic [2:0]            rc_q, rc_d;           // column of the read on the bus
    logic [1:0]            di_q, di_d;           // row of the write on the bus
    logic [1:0]            dj_q, dj_d;           // column of the write on the bus
    logic [TOW-1:0]        to_cnt_q, to_cnt_d;
    logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                  rd_en_q, rd_en_d, eng_start_q, eng_start_d, wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [NBITS-1:0]      wr_data_q, wr_data_d;
    logic [25*NBITS-1:0]   tile_q, tile_d;
    logic [9*NBITS-1:0]    res_q, res_d;

    logic [2:0]            rr_nxt_s, rc_nxt_s;
    logic [1:0]            di_nxt_s, dj_nxt_s;
    logic [TXW-1:0]        tx_nxt_s;
    logic [TYW-1:0]        ty_nxt_s;
    logic                  tx_last_s, last_tile_s;

    // Ifmap address of element (r,c) of tile (tx,ty).
    function automatic logic [ADDR_W-1:0] rd_addr_f(input logic [TXW-1:0] tx, input logic [TYW-1:0] ty,
                                                    input logic [2:0] r, input logic [2:0] c);
        return ADDR_W'((32'd3 * 32'(ty) + 32'(r)) * 32'(IMG_W) + 32'd3 * 32'(tx) + 32'(c));
    endfunction

    // Ofmap address of result (i,j) of tile (tx,ty).
    function automatic logic [ADDR_W-1:0] wr_addr_f(input logic [TXW-1:0] tx, input logic [TYW-1:0] ty,
                                                    input logic [1:0] i, input logic [1:0] j);
        return ADDR_W'((32'd3 * 32'(ty) + 32'(i)) * 32'(OUT_W) + 32'd3 * 32'(tx) + 32'(j));
    endfunction

    // Result word i*3+j of a packed 3x3 result.
    function automatic logic [NBITS-1:0] res_word_f(input logic [9*NBITS-1:0] res,
                                                    input logic [1:0] i, input logic [1:0] j);
        return res[(int'(i) * 3 + int'(j)) * NBITS +: NBITS];
    endfunction

    // Row-major successors for the read/write element walks and the tile walk.
    assign rc_nxt_s    = (rc_q == 3'd4) ? 3'd0 : rc_q + 3'd1;
    assign rr_nxt_s    = (rc_q == 3'd4) ? rr_q + 3'd1 : rr_q;
    assign dj_nxt_s    = (dj_q == 2'd2) ? 2'd0 : dj_q + 2'd1;
    assign di_nxt_s    = (dj_q == 2'd2) ? di_q + 2'd1 : di_q;
    assign tx_last_s   = (tx_q == TXW'(TILES_X - 1));
    assign tx_nxt_s    = tx_last_s ? '0 : tx_q + TXW'(1);
    assign ty_nxt_s    = tx_last_s ? ty_q + TYW'(1) : ty_q;
    assign last_tile_s = tx_last_s && (ty_q == TYW'(TILES_Y - 1));

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        ty_d        = ty_q;
        ld_cnt_d    = ld_cnt_q;
        rr_d        = rr_q;
        rc_d        = rc_q;
        di_d        = di_q;
        dj_d        = dj_q;
        to_cnt_d    = to_cnt_q;
        busy_d      = busy_q;
        err_d       = err_q;
        done_d      = 1'b0;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        eng_start_d = 1'b0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        tile_d      = tile_q;
        res_d       = res_q;
        case (state_q)
            S_IDLE: begin
                if (job_start) begin
                    state_d   = S_LOAD;
                    tx_d      = '0;
                    ty_d      = '0;
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                    ld_cnt_d  = 5'd0;
                    rr_d      = 3'd0;
                    rc_d      = 3'd0;
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_f('0, '0, 3'd0, 3'd0);
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_LOAD: begin
                // Data for the read issued last cycle is on rd_data now.
                if (ld_cnt_q != 5'd0) begin
                    tile_d[(int'(ld_cnt_q) - 1) * NBITS +: NBITS] = rd_data;
                end else begin
                    tile_d = tile_q;
                end
                if (ld_cnt_q == 5'd25) begin
                    state_d     = S_FIRE;
                    eng_start_d = 1'b1;
                end else begin
                    ld_cnt_d = ld_cnt_q + 5'd1;
                    if (ld_cnt_q < 5'd24) begin
                        rr_d      = rr_nxt_s;
                        rc_d      = rc_nxt_s;
                        rd_en_d   = 1'b1;
                        rd_addr_d = rd_addr_f(tx_q, ty_q, rr_nxt_s, rc_nxt_s);
                    end else begin
                        rd_en_d = 1'b0;
                    end
                end
            end
            S_FIRE: begin
                state_d  = S_WAIT;
                to_cnt_d = '0;
            end
            S_WAIT: begin
                if (eng_data_valid) begin
                    // First word goes straight from the engine; the rest from res_q.
                    res_d     = eng_outputMAP;
                    state_d   = S_DRAIN;
                    di_d      = 2'd0;
                    dj_d      = 2'd0;
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr_f(tx_q, ty_q, 2'd0, 2'd0);
                    wr_data_d = eng_outputMAP[NBITS-1:0];
                end else if (to_cnt_q == TOW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + TOW'(1);
                end
            end
            S_DRAIN: begin
                if ((di_q == 2'd2) && (dj_q == 2'd2)) begin
                    state_d = S_NEXT;
                end else begin
                    di_d      = di_nxt_s;
                    dj_d      = dj_nxt_s;
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr_f(tx_q, ty_q, di_nxt_s, dj_nxt_s);
                    wr_data_d = res_word_f(res_q, di_nxt_s, dj_nxt_s);
                end
            end
            S_NEXT: begin
                if (last_tile_s) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    tx_d      = tx_nxt_s;
                    ty_d      = ty_nxt_s;
                    state_d   = S_LOAD;
                    ld_cnt_d  = 5'd0;
                    rr_d      = 3'd0;
                    rc_d      = 3'd0;
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_f(tx_nxt_s, ty_nxt_s, 3'd0, 3'd0);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tx_q        <= '0;
            ty_q        <= '0;
            ld_cnt_q    <= 5'd0;
            rr_q        <= 3'd0;
            rc_q        <= 3'd0;
            di_q        <= 2'd0;
            dj_q        <= 2'd0;
            to_cnt_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            eng_start_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            tile_q      <= '0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            ty_q        <= ty_d;
            ld_cnt_q    <= ld_cnt_d;
            rr_q        <= rr_d;
            rc_q        <= rc_d;
            di_q        <= di_d;
            dj_q        <= dj_d;
            to_cnt_q    <= to_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            eng_start_q <= eng_start_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            tile_q      <= tile_d;
            res_q       <= res_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign rd_en        = rd_en_q;
    assign rd_addr      = rd_addr_q;
    assign eng_start    = eng_start_q;
    assign eng_inputMAP = tile_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;

endmodule
